// File: rtl/hbm_send_back_mc.sv
// hbm_send_back_mc: per-lane FWFT FIFOs drained round-robin into
// burst-sized DMA write commands, one burst per channel visit.
module hbm_send_back_mc #(
    parameter int DATA_WIDTH      = 512,
    parameter int NUM_CH          = 4,
    parameter int FIFO_DEPTH      = 512,
    parameter int MAX_BURST_BYTES = 4096,
    parameter int AF_THRESH       = FIFO_DEPTH - 32
) (
    input  logic                         hbm_clk,
    input  logic                         hbm_rst,
    input  logic                         start,
    input  logic [63:0]                  addr_x,
    input  logic [63:0]                  ch_stride,
    input  logic [31:0]                  data_length,
    input  logic [NUM_CH*DATA_WIDTH-1:0] back_data,
    input  logic [NUM_CH-1:0]            back_valid,
    output logic [NUM_CH-1:0]            almost_full,
    output logic [NUM_CH-1:0]            overflow,
    output logic                         busy,
    output logic                         done,
    output logic                         m_axis_dma_write_cmd_valid,
    input  logic                         m_axis_dma_write_cmd_ready,
    output logic [63:0]                  m_axis_dma_write_cmd_address,
    output logic [31:0]                  m_axis_dma_write_cmd_length,
    output logic                         m_axis_dma_write_data_valid,
    input  logic                         m_axis_dma_write_data_ready,
    output logic [DATA_WIDTH-1:0]        m_axis_dma_write_data_data,
    output logic [DATA_WIDTH/8-1:0]      m_axis_dma_write_data_keep,
    output logic                         m_axis_dma_write_data_last
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int BB_LOG2    = $clog2(BEAT_BYTES);
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CNTW       = PW + 1;
    localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PICK, S_SEND_CMD, S_SEND_DATA, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]         rr_ptr, cur, sel, idx;
    logic                  found, any_rem;
    logic [31:0]           beat_cnt;
    logic                  start_acc, data_hs, last_hs;

    logic [NUM_CH-1:0]     in_valid;
    logic [DATA_WIDTH-1:0] in_data     [NUM_CH];
    logic [DATA_WIDTH-1:0] head        [NUM_CH];
    logic [CNTW-1:0]       count       [NUM_CH];
    logic [31:0]           remaining   [NUM_CH];
    logic [63:0]           next_addr   [NUM_CH];
    logic [31:0]           burst_bytes [NUM_CH];
    logic [31:0]           burst_beats [NUM_CH];

    assign start_acc = (state == S_IDLE) && start;
    assign data_hs   = m_axis_dma_write_data_valid && m_axis_dma_write_data_ready;
    assign last_hs   = data_hs && m_axis_dma_write_data_last;

    always_ff @(posedge hbm_clk) begin
        if (hbm_rst) begin
            in_valid <= '0;
        end else begin
            in_valid <= back_valid;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            in_data[c] <= back_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0]         wr_ptr, rd_ptr;
        logic [CNTW-1:0]       cnt;
        logic [31:0]           rem;
        logic [63:0]           addr;
        logic                  wr_en, rd_en, af, ovf;

        assign wr_en = in_valid[g] && (cnt != CNTW'(FIFO_DEPTH));
        assign rd_en = data_hs && (cur == CW'(g));

        assign head[g]      = mem[rd_ptr];
        assign count[g]     = cnt;
        assign remaining[g] = rem;
        assign next_addr[g] = addr;
        assign almost_full[g] = af;
        assign overflow[g]    = ovf;

        assign burst_bytes[g] = (rem > 32'(MAX_BURST_BYTES)) ?
                                32'(MAX_BURST_BYTES) : rem;
        assign burst_beats[g] = burst_bytes[g] >> BB_LOG2;

        always_ff @(posedge hbm_clk) begin
            if (wr_en) mem[wr_ptr] <= in_data[g];
        end

        always_ff @(posedge hbm_clk) begin
            if (hbm_rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                af     <= 1'b0;
                ovf    <= 1'b0;
                rem    <= '0;
                addr   <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + PW'(1);
                if (rd_en) rd_ptr <= rd_ptr + PW'(1);
                cnt <= cnt + CNTW'(wr_en) - CNTW'(rd_en);
                af  <= (32'(cnt) >= 32'(AF_THRESH));
                if (in_valid[g] && !wr_en) ovf <= 1'b1;
                // sub-beat tail of the length is dropped
                if (start_acc) begin
                    rem  <= data_length & ~32'(BEAT_BYTES - 1);
                    addr <= addr_x + 64'(g) * ch_stride;
                end else if (last_hs && cur == CW'(g)) begin
                    rem  <= rem - burst_bytes[g];
                    addr <= addr + 64'(burst_bytes[g]);
                end
            end
        end
    end

    // first eligible channel at or after rr_ptr, wrapping once
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        idx     = '0;
        any_rem = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(rr_ptr) + i >= NUM_CH) idx = CW'(int'(rr_ptr) + i - NUM_CH);
            else                            idx = CW'(int'(rr_ptr) + i);
            any_rem = any_rem | (remaining[i] != '0);
            if (!found && remaining[idx] != '0 &&
                32'(count[idx]) >= burst_beats[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:      if (start) state_nx = S_PICK;
            S_PICK: begin
                if (!any_rem)   state_nx = S_DONE;
                else if (found) state_nx = S_SEND_CMD;
            end
            S_SEND_CMD:  if (m_axis_dma_write_cmd_ready) state_nx = S_SEND_DATA;
            S_SEND_DATA: if (last_hs) state_nx = S_PICK;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge hbm_clk) begin
        if (hbm_rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            cur      <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_PICK && found) cur <= sel;
            if (state == S_SEND_CMD)  beat_cnt <= '0;
            else if (data_hs)         beat_cnt <= beat_cnt + 32'd1;
            if (last_hs) begin
                rr_ptr <= (cur == CW'(NUM_CH - 1)) ? '0 : cur + CW'(1);
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    assign m_axis_dma_write_cmd_valid   = (state == S_SEND_CMD);
    assign m_axis_dma_write_cmd_address =
        m_axis_dma_write_cmd_valid ? next_addr[cur] : '0;
    assign m_axis_dma_write_cmd_length  =
        m_axis_dma_write_cmd_valid ? burst_bytes[cur] : '0;

    assign m_axis_dma_write_data_valid =
        (state == S_SEND_DATA) && (count[cur] != '0);
    assign m_axis_dma_write_data_data =
        m_axis_dma_write_data_valid ? head[cur] : '0;
    assign m_axis_dma_write_data_last =
        m_axis_dma_write_data_valid && (beat_cnt == burst_beats[cur] - 32'd1);
    assign m_axis_dma_write_data_keep = '1;

endmodule

// File: tb/tb_hbm_send_back_mc.sv
// tb_hbm_send_back_mc: randomized stimulus, queue scoreboard, and a
// burst-level round-robin model of the write-back engine.
module tb_hbm_send_back_mc;

    localparam int DW    = 512;
    localparam int NCH   = 4;
    localparam int DEPTH = 512;
    localparam int MAXB  = 4096;
    localparam int AFT   = DEPTH - 32;
    localparam int BB    = DW / 8;

    logic              hbm_clk = 1'b0;
    logic              hbm_rst = 1'b1;
    logic              start = 1'b0;
    logic [63:0]       addr_x = '0;
    logic [63:0]       ch_stride = '0;
    logic [31:0]       data_length = '0;
    logic [NCH*DW-1:0] back_data = '0;
    logic [NCH-1:0]    back_valid = '0;
    logic [NCH-1:0]    almost_full, overflow;
    logic              busy, done;
    logic              cmd_valid, cmd_ready = 1'b1;
    logic [63:0]       cmd_addr;
    logic [31:0]       cmd_len;
    logic              data_valid, data_ready = 1'b1;
    logic [DW-1:0]     data_data;
    logic [DW/8-1:0]   data_keep;
    logic              data_last;

    hbm_send_back_mc dut (
        .hbm_clk                      (hbm_clk),
        .hbm_rst                      (hbm_rst),
        .start                        (start),
        .addr_x                       (addr_x),
        .ch_stride                    (ch_stride),
        .data_length                  (data_length),
        .back_data                    (back_data),
        .back_valid                   (back_valid),
        .almost_full                  (almost_full),
        .overflow                     (overflow),
        .busy                         (busy),
        .done                         (done),
        .m_axis_dma_write_cmd_valid   (cmd_valid),
        .m_axis_dma_write_cmd_ready   (cmd_ready),
        .m_axis_dma_write_cmd_address (cmd_addr),
        .m_axis_dma_write_cmd_length  (cmd_len),
        .m_axis_dma_write_data_valid  (data_valid),
        .m_axis_dma_write_data_ready  (data_ready),
        .m_axis_dma_write_data_data   (data_data),
        .m_axis_dma_write_data_keep   (data_keep),
        .m_axis_dma_write_data_last   (data_last)
    );

    always #5 hbm_clk = ~hbm_clk;

    typedef struct { logic [63:0] addr; logic [31:0] len; } cmd_t;
    typedef struct { logic [DW-1:0] data; logic last; } beat_t;

    cmd_t          exp_cmd[$];
    beat_t         exp_beat[$];
    logic [DW-1:0] mq [NCH][$];
    logic [63:0]   m_addr [NCH];
    logic [31:0]   m_rem  [NCH];
    int            model_rr = 0;
    logic [NCH-1:0] exp_ovf = '0;

    int vectors = 0;
    int miscompares = 0;
    int beats_seen = 0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // reference: one burst = min(remaining, MAXB) bytes from channel c
    task automatic serve(input int c);
        logic [31:0] blen;
        int nb;
        cmd_t e;
        beat_t b;
        blen = (m_rem[c] > 32'(MAXB)) ? 32'(MAXB) : m_rem[c];
        e.addr = m_addr[c];
        e.len  = blen;
        exp_cmd.push_back(e);
        nb = int'(blen) / BB;
        for (int k = 0; k < nb; k++) begin
            b.data = (mq[c].size() > 0) ? mq[c].pop_front() : '0;
            b.last = (k == nb - 1);
            exp_beat.push_back(b);
        end
        m_rem[c]  = m_rem[c] - blen;
        m_addr[c] = m_addr[c] + 64'(blen);
        model_rr  = (c + 1) % NCH;
    endtask

    task automatic job_setup(input logic [63:0] base, input logic [63:0] stride, input logic [31:0] len);
        for (int c = 0; c < NCH; c++) begin
            m_rem[c]  = (len / BB) * BB;
            m_addr[c] = base + 64'(c) * stride;
        end
    endtask

    // all data already buffered: plain rotation over unfinished channels
    task automatic plan_rest();
        bit any;
        int c;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                c = (model_rr + i) % NCH;
                if (!any && m_rem[c] != 0) begin
                    any = 1'b1;
                    serve(c);
                end
            end
        end
    endtask

    task automatic push(input logic [NCH-1:0] mask, input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            @(posedge hbm_clk); #1;
            back_valid = mask;
            for (int c = 0; c < NCH; c++) begin
                d = rnd();
                back_data[c*DW +: DW] = d;
                if (mask[c]) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(d);
                    else exp_ovf[c] = 1'b1;
                end
            end
        end
        @(posedge hbm_clk); #1;
        back_valid = '0;
    endtask

    task automatic do_start(input logic [63:0] a, input logic [63:0] s, input logic [31:0] l);
        @(posedge hbm_clk); #1;
        start = 1'b1; addr_x = a; ch_stride = s; data_length = l;
        @(posedge hbm_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge hbm_clk);
            if (done) begin
                cyc = i + 1;
                break;
            end
        end
        if (cyc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done within %0d cycles", budget);
        end
    endtask

    task automatic finish_job(input string name, input int budget);
        int cyc;
        wait_done(budget, cyc);
        chk({name, "_cmds_left"}, 64'(exp_cmd.size()), 64'd0);
        chk({name, "_beats_left"}, 64'(exp_beat.size()), 64'd0);
        @(negedge hbm_clk);
        chk({name, "_done_width"}, 64'(done), 64'd0);
        chk({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        chk({name, "_cmd_addr"}, cmd_addr, 64'd0);
        chk({name, "_cmd_len"}, 64'(cmd_len), 64'd0);
        chk({name, "_data_valid"}, 64'(data_valid), 64'd0);
        chk_w({name, "_data"}, data_data, '0);
        chk({name, "_last"}, 64'(data_last), 64'd0);
        chk({name, "_keep"}, data_keep, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_done"}, 64'(done), 64'd0);
        chk({name, "_almost_full"}, 64'(almost_full), 64'd0);
        chk({name, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    task automatic model_flush();
        exp_cmd.delete();
        exp_beat.delete();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        model_rr = 0;
        exp_ovf  = '0;
    endtask

    initial begin
        forever begin
            @(posedge hbm_clk); #1;
            if (rand_rdy) begin
                cmd_ready  = ($urandom_range(3) != 0);
                data_ready = ($urandom_range(3) != 0);
            end else begin
                cmd_ready  = 1'b1;
                data_ready = 1'b1;
            end
        end
    end

    // monitor: pops the scoreboard on every DUT handshake
    initial begin
        cmd_t          ec;
        beat_t         eb;
        bit            hold_pend;
        logic [DW-1:0] hold_d;
        hold_pend = 1'b0;
        hold_d    = '0;
        forever begin
            @(negedge hbm_clk);
            if (hbm_rst) begin
                hold_pend = 1'b0;
            end else begin
                if (cmd_valid && data_valid) begin
                    miscompares++;
                    $display("FAIL cmd_data_overlap: got both valid expected one");
                end
                if (hold_pend && (!data_valid || data_data !== hold_d)) begin
                    miscompares++;
                    $display("FAIL data_hold: got valid=%0b changed data expected stable", data_valid);
                end
                hold_pend = data_valid && !data_ready;
                hold_d    = data_data;
                if (cmd_valid && cmd_ready) begin
                    if (exp_cmd.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_cmd: got addr %0h len %0d expected none", cmd_addr, cmd_len);
                    end else begin
                        ec = exp_cmd.pop_front();
                        chk("cmd_addr", cmd_addr, ec.addr);
                        chk("cmd_len", 64'(cmd_len), 64'(ec.len));
                    end
                end
                if (data_valid && data_ready) begin
                    beats_seen++;
                    if (exp_beat.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got beat expected none");
                    end else begin
                        eb = exp_beat.pop_front();
                        chk_w("beat_data", data_data, eb.data);
                        chk("beat_last", 64'(data_last), 64'(eb.last));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int seen0;

        repeat (3) @(negedge hbm_clk);
        chk_idle_outputs("reset");
        @(posedge hbm_clk); #1;
        hbm_rst = 1'b0;

        // short job, one 4-beat burst per channel
        push(4'hF, 4);
        job_setup(64'h1000_0000_0000, 64'h2000, 32'd256);
        plan_rest();
        do_start(64'h1000_0000_0000, 64'h2000, 32'd256);
        chk("busy_on_start", 64'(busy), 64'd1);
        finish_job("job256", 500);

        // two rounds of full bursts with random backpressure
        rand_rdy = 1'b1;
        push(4'hF, 128);
        job_setup(64'hABC0_0000, 64'h1_0000, 32'd8192);
        plan_rest();
        do_start(64'hABC0_0000, 64'h1_0000, 32'd8192);
        repeat (3) @(posedge hbm_clk);
        do_start(64'hDEAD_0000, 64'h40, 32'd128);
        finish_job("job8192", 5000);

        // zero-length and sub-beat jobs finish without commands
        rand_rdy = 1'b0;
        do_start(64'h100, 64'h100, 32'd0);
        wait_done(10, cyc);
        chk("zero_len_done_latency", 64'(cyc >= 1 && cyc <= 3), 64'd1);
        do_start(64'h200, 64'h100, 32'd63);
        wait_done(10, cyc);
        chk("len63_done_latency", 64'(cyc >= 1 && cyc <= 3), 64'd1);
        repeat (10) @(negedge hbm_clk);
        chk("short_jobs_idle", 64'(busy), 64'd0);

        // only ch2 ready: it goes first, then rotation resumes at ch3
        push(4'b0100, 64);
        job_setup(64'h5000_0000, 64'h1_0000_0000, 32'd4096);
        serve(2);
        do_start(64'h5000_0000, 64'h1_0000_0000, 32'd4096);
        for (int i = 0; i < 400 && (exp_beat.size() != 0); i++) @(negedge hbm_clk);
        repeat (10) @(negedge hbm_clk);
        chk("ch2_first_beats_left", 64'(exp_beat.size()), 64'd0);
        chk("ch2_waiting_busy", 64'(busy), 64'd1);
        push(4'b1011, 64);
        plan_rest();
        finish_job("job_ch2", 1000);

        // fill to threshold, then past full on ch1
        rand_rdy = 1'b1;
        push(4'hF, AFT - 1);
        repeat (4) @(negedge hbm_clk);
        chk("af_below_thresh", 64'(almost_full), 64'd0);
        push(4'hF, 1);
        repeat (4) @(negedge hbm_clk);
        chk("af_at_thresh", 64'(almost_full), 64'hF);
        push(4'hF, DEPTH - AFT);
        repeat (4) @(negedge hbm_clk);
        chk("ovf_at_full", 64'(overflow), 64'd0);
        push(4'b0010, 3);
        repeat (4) @(negedge hbm_clk);
        chk("ovf_past_full", 64'(overflow), 64'(exp_ovf));
        job_setup(64'h0, 64'h10_0000, 32'(DEPTH * BB));
        plan_rest();
        do_start(64'h0, 64'h10_0000, 32'(DEPTH * BB));
        finish_job("job_drain", 20000);
        chk("ovf_sticky", 64'(overflow), 64'(exp_ovf));
        chk("af_after_drain", 64'(almost_full), 64'd0);

        // reset in the middle of a burst
        push(4'hF, 64);
        job_setup(64'h7000, 64'h1000, 32'd4096);
        plan_rest();
        do_start(64'h7000, 64'h1000, 32'd4096);
        seen0 = beats_seen;
        for (int i = 0; i < 1000 && beats_seen < seen0 + 20; i++) @(negedge hbm_clk);
        chk("pre_reset_progress", 64'(beats_seen >= seen0 + 20), 64'd1);
        @(posedge hbm_clk); #1;
        hbm_rst = 1'b1;
        model_flush();
        @(posedge hbm_clk);
        @(negedge hbm_clk);
        chk_idle_outputs("midreset");
        @(posedge hbm_clk); #1;
        hbm_rst = 1'b0;
        seen0 = beats_seen;
        repeat (20) @(negedge hbm_clk);
        chk("no_beats_after_reset", 64'(beats_seen), 64'(seen0));

        rand_rdy = 1'b0;
        push(4'hF, 4);
        job_setup(64'h9000_0000, 64'h400, 32'd256);
        plan_rest();
        do_start(64'h9000_0000, 64'h400, 32'd256);
        finish_job("job_post_reset", 500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
